// File: rtl/johnson_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : johnson_pkg                                               |
// | Brief    : Shared mode/direction codes and reset-code helper for the |
// |            Johnson/ring counter.                                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package johnson_pkg;

  typedef enum logic {
    MODE_JOHNSON = 1'b0,
    MODE_RING    = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Phase-0 code of each mode; callers truncate to their own width.
  function automatic logic [MAX_WIDTH-1:0] reset_code(input logic mode);
    return (mode == MODE_RING) ? 32'd1 : 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_phase_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : johnson_phase_decode                                      |
// | Brief    : Combinational legality check and phase index of a code    |
// |            in Johnson or ring mode.                                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             legal,
  output logic [PW-1:0]    phase
);

  localparam logic [WIDTH-1:0] ONES = '1;

  int               pc;
  int               ring_idx;
  logic [WIDTH-1:0] low_mask;
  logic [WIDTH-1:0] high_mask;

  always_comb begin
    pc       = 0;
    ring_idx = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q[i]) begin
        pc       = pc + 1;
        ring_idx = i;
      end
    end

    // Legal Johnson codes are a run of ones anchored at either end.
    low_mask  = ONES >> (WIDTH - pc);
    high_mask = ~(ONES >> pc);

    legal = 1'b0;
    phase = '0;
    if (mode == MODE_RING) begin
      legal = (pc == 1);
      if (legal) phase = PW'(ring_idx);
    end else begin
      legal = (q == low_mask) || (q == high_mask);
      if (legal) begin
        if (q[0])
          phase = PW'(pc);
        else if (pc != 0)
          phase = PW'(2*WIDTH - pc);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/johnson_counter_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : johnson_counter_p                                         |
// | Brief    : Bidirectional Johnson/ring counter with load, automatic   |
// |            illegal-code correction, phase index and wrap pulse.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module johnson_counter_p
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             illegal
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] q_rst;
  logic [WIDTH-1:0] step_fwd;
  logic [WIDTH-1:0] step_rev;
  logic [PW-1:0]    last_phase;
  logic             twist;
  logic             cur_legal;
  logic [PW-1:0]    cur_phase;
  logic             nxt_legal;
  logic [PW-1:0]    nxt_phase;

  // Current code in the current mode drives correction and wrap detection.
  johnson_phase_decode #(.WIDTH(WIDTH), .PW(PW)) u_cur_decode (
    .q     (q_q),
    .mode  (mode),
    .legal (cur_legal),
    .phase (cur_phase)
  );

  // Next code is decoded ahead so phase stays aligned with q.
  johnson_phase_decode #(.WIDTH(WIDTH), .PW(PW)) u_nxt_decode (
    .q     (q_d),
    .mode  (mode),
    .legal (nxt_legal),
    .phase (nxt_phase)
  );

  assign q_rst      = WIDTH'(reset_code(mode));
  assign twist      = (mode == MODE_JOHNSON);
  assign last_phase = (mode == MODE_RING) ? PW'(WIDTH - 1) : PW'(2*WIDTH - 1);
  assign step_fwd   = {q_q[WIDTH-2:0], q_q[WIDTH-1] ^ twist};
  assign step_rev   = {q_q[0] ^ twist, q_q[WIDTH-1:1]};

  always_comb begin
    q_d       = q_q;
    wrap_d    = 1'b0;
    illegal_d = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (!cur_legal) begin
      q_d       = q_rst;
      illegal_d = 1'b1;
    end else if (en) begin
      if (dir == DIR_REV) begin
        q_d    = step_rev;
        wrap_d = (cur_phase == '0);
      end else begin
        q_d    = step_fwd;
        wrap_d = (cur_phase == last_phase);
      end
    end
    phase_d = nxt_legal ? nxt_phase : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= q_rst;
      phase_q   <= '0;
      wrap_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      phase_q   <= phase_d;
      wrap_q    <= wrap_d;
      illegal_q <= illegal_d;
    end
  end

  assign q       = q_q;
  assign phase   = phase_q;
  assign wrap    = wrap_q;
  assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_johnson_counter_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_johnson_counter_p                                      |
// | Brief    : Directed and randomized self-checking bench for           |
// |            johnson_counter_p at WIDTH=4.                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_johnson_counter_p;

  localparam int W  = 4;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst, en, dir, mode, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  q;
  logic [PW-1:0] phase;
  logic          wrap, illegal;

  int checks   = 0;
  int failures = 0;

  // Reference state: the code held, plus expected aligned outputs.
  int   m_q     = 0;
  int   m_phase = 0;
  logic m_wrap  = 1'b0;
  logic m_ill   = 1'b0;

  always #5 clk = ~clk;

  johnson_counter_p #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .phase    (phase),
    .wrap     (wrap),
    .illegal  (illegal)
  );

  function automatic int n_codes(input logic m);
    return m ? W : 2*W;
  endfunction

  // The k-th code of the cycle starting from the reset code.
  function automatic int code_at(input logic m, input int k);
    if (m) return 1 << k;
    if (k <= W) return (1 << k) - 1;
    return ((1 << W) - 1) & ~((1 << (k - W)) - 1);
  endfunction

  function automatic int index_of(input logic m, input int v);
    for (int k = 0; k < n_codes(m); k++)
      if (code_at(m, k) == v) return k;
    return -1;
  endfunction

  task automatic step(input logic r, input logic ld, input logic [W-1:0] lv,
                      input logic e, input logic d, input logic m);
    int k;
    int n;
    rst = r; load = ld; load_val = lv; en = e; dir = d; mode = m;
    n = n_codes(m);
    k = index_of(m, m_q);
    m_wrap = 1'b0;
    m_ill  = 1'b0;
    if (r) m_q = m ? 1 : 0;
    else if (ld) m_q = int'(lv);
    else if (k < 0) begin
      m_q   = m ? 1 : 0;
      m_ill = 1'b1;
    end else if (e) begin
      if (d) begin
        m_q    = code_at(m, (k + n - 1) % n);
        m_wrap = (k == 0);
      end else begin
        m_q    = code_at(m, (k + 1) % n);
        m_wrap = (k == n - 1);
      end
    end
    k = index_of(m, m_q);
    m_phase = (k < 0) ? 0 : k;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1, 0, 4'h0, 0, 0, 0);
    checks++;
    if ({q, phase, wrap, illegal} !== 9'b0000_000_0_0) begin
      failures++;
      $display("FAIL reset_johnson: got q/ph/wr/il=%b expected %b", {q, phase, wrap, illegal}, 9'b0000_000_0_0);
    end
    step(1, 1, 4'h6, 1, 0, 1);
    checks++;
    if ({q, phase, wrap, illegal} !== 9'b0001_000_0_0) begin
      failures++;
      $display("FAIL reset_ring: got q/ph/wr/il=%b expected %b", {q, phase, wrap, illegal}, 9'b0001_000_0_0);
    end
  endtask

  task automatic test_johnson_fwd;
    logic [W-1:0] exp_q [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    logic [8:0]   exp;
    step(1, 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 4'h0, 1, 0, 0);
      exp = {exp_q[i], 3'((i + 1) % 8), (i == 7), 1'b0};
      checks++;
      if ({q, phase, wrap, illegal} !== exp) begin
        failures++;
        $display("FAIL johnson_fwd[%0d]: got q/ph/wr/il=%b expected %b", i, {q, phase, wrap, illegal}, exp);
      end
    end
  endtask

  task automatic test_johnson_rev;
    step(0, 0, 4'h0, 1, 1, 0);
    checks++;
    if ({q, phase, wrap, illegal} !== 9'b1000_111_1_0) begin
      failures++;
      $display("FAIL johnson_rev: got q/ph/wr/il=%b expected %b", {q, phase, wrap, illegal}, 9'b1000_111_1_0);
    end
  endtask

  task automatic test_ring;
    logic [W-1:0] exp_q [4] = '{4'h2, 4'h4, 4'h8, 4'h1};
    logic [8:0]   exp;
    step(1, 0, 4'h0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'h0, 1, 0, 1);
      exp = {exp_q[i], 3'((i + 1) % 4), (i == 3), 1'b0};
      checks++;
      if ({q, phase, wrap, illegal} !== exp) begin
        failures++;
        $display("FAIL ring_fwd[%0d]: got q/ph/wr/il=%b expected %b", i, {q, phase, wrap, illegal}, exp);
      end
    end
  endtask

  task automatic test_load_illegal;
    for (int e = 0; e < 2; e++) begin
      step(1, 0, 4'h0, 0, 0, 0);
      step(0, 1, 4'b0101, e[0], 0, 0);
      checks++;
      if ({q, phase, wrap, illegal} !== 9'b0101_000_0_0) begin
        failures++;
        $display("FAIL load_illegal en=%0d: got q/ph/wr/il=%b expected %b", e, {q, phase, wrap, illegal}, 9'b0101_000_0_0);
      end
      step(0, 0, 4'h0, e[0], 0, 0);
      checks++;
      if ({q, phase, wrap, illegal} !== 9'b0000_000_0_1) begin
        failures++;
        $display("FAIL correction en=%0d: got q/ph/wr/il=%b expected %b", e, {q, phase, wrap, illegal}, 9'b0000_000_0_1);
      end
    end
  endtask

  task automatic test_mode_switch;
    step(1, 0, 4'h0, 0, 0, 0);
    step(0, 0, 4'h0, 1, 0, 0);
    step(0, 0, 4'h0, 1, 0, 0);
    checks++;
    if ({q, phase, wrap, illegal} !== 9'b0011_010_0_0) begin
      failures++;
      $display("FAIL mode_pre: got q/ph/wr/il=%b expected %b", {q, phase, wrap, illegal}, 9'b0011_010_0_0);
    end
    step(0, 0, 4'h0, 1, 0, 1);
    checks++;
    if ({q, phase, wrap, illegal} !== 9'b0001_000_0_1) begin
      failures++;
      $display("FAIL mode_to_ring: got q/ph/wr/il=%b expected %b", {q, phase, wrap, illegal}, 9'b0001_000_0_1);
    end
    step(0, 0, 4'h0, 1, 0, 0);
    checks++;
    if ({q, phase, wrap, illegal} !== 9'b0011_010_0_0) begin
      failures++;
      $display("FAIL mode_to_johnson: got q/ph/wr/il=%b expected %b", {q, phase, wrap, illegal}, 9'b0011_010_0_0);
    end
  endtask

  task automatic test_reset_override;
    step(0, 0, 4'h0, 1, 0, 0);
    step(1, 1, 4'h9, 1, 0, 0);
    checks++;
    if ({q, phase, wrap, illegal} !== 9'b0000_000_0_0) begin
      failures++;
      $display("FAIL reset_override: got q/ph/wr/il=%b expected %b", {q, phase, wrap, illegal}, 9'b0000_000_0_0);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'h0, 0, 0, 0);
      checks++;
      if ({q, phase, wrap, illegal} !== 9'b0000_000_0_0) begin
        failures++;
        $display("FAIL hold[%0d]: got q/ph/wr/il=%b expected %b", i, {q, phase, wrap, illegal}, 9'b0000_000_0_0);
      end
    end
  endtask

  task automatic test_random;
    logic       cur_mode;
    logic [8:0] exp;
    cur_mode = 1'b0;
    step(1, 0, 4'h0, 0, 0, cur_mode);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(15) == 0) cur_mode = ~cur_mode;
      step(($urandom_range(39) == 0), ($urandom_range(7) == 0), 4'($urandom),
           ($urandom_range(3) != 0), 1'($urandom), cur_mode);
      exp = {m_q[3:0], m_phase[2:0], m_wrap, m_ill};
      checks++;
      if ({q, phase, wrap, illegal} !== exp) begin
        failures++;
        $display("FAIL random[%0d]: got q/ph/wr/il=%b expected %b", i, {q, phase, wrap, illegal}, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
    test_reset();
    test_johnson_fwd();
    test_johnson_rev();
    test_ring();
    test_load_illegal();
    test_mode_switch();
    test_reset_override();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/johnson_counter_p.md
JOHNSON_COUNTER_P -- requirements
Module: johnson_counter_p

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set counter width; legal range 2..32.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 en  in  1  SHALL enable one advance per cycle when high.
REQ-005 dir  in  1  SHALL select direction: 0 = forward (shift toward MSB), 1 = reverse.
REQ-006 mode  in  1  SHALL select code: 0 = Johnson (twisted ring), 1 = ring (one-hot).
REQ-007 load  in  1  SHALL request a synchronous load of load_val.
REQ-008 load_val  in  WIDTH  SHALL be the value captured when load=1.
REQ-009 q  out  WIDTH  SHALL be the registered counter state.
REQ-010 phase  out  clog2(2*WIDTH)  SHALL be the registered phase index of q.
REQ-011 wrap  out  1  SHALL be a registered one-cycle wrap pulse.
REQ-012 illegal  out  1  SHALL be a registered one-cycle correction pulse.

Function
REQ-013 Update priority each cycle SHALL be: rst > load > correction > advance (en) > hold.
REQ-014 Johnson forward SHALL give q <= {q[W-2:0], ~q[W-1]}; reverse SHALL give q <= {~q[0], q[W-1:1]}.
REQ-015 Ring forward SHALL give q <= {q[W-2:0], q[W-1]}; reverse SHALL give q <= {q[0], q[W-1:1]}.
REQ-016 Johnson legal set SHALL be exactly the 2*WIDTH codes reachable from all-zeros; ring legal set SHALL be exactly the WIDTH one-hot codes.
REQ-017 Johnson phase SHALL equal popcount(q) when q[0]=1, else (2*WIDTH - popcount(q)) mod 2*WIDTH; ring phase SHALL equal the index of the set bit.
REQ-018 phase SHALL be 0 whenever q is illegal for the current mode.
REQ-019 If q is illegal for the current mode (from load or mode change), the next cycle SHALL force q to the reset code of the current mode, regardless of en, and pulse illegal=1 for that cycle.
REQ-020 Load SHALL write load_val unchanged (no legality filtering); correction, if needed, follows on the next cycle.
REQ-021 mode SHALL be sampled every cycle; a code legal in the new mode SHALL continue counting from its phase in that mode without correction.
REQ-022 wrap SHALL be 1 in the cycle after an advance moves phase from last (2W-1 Johnson, W-1 ring) to 0 forward, or from 0 to last reverse; 0 on load, correction, hold, reset.
REQ-023 phase, wrap and illegal SHALL be aligned with the q value they describe (zero added latency relative to q).
REQ-024 en=0 with no load and legal q SHALL hold q and phase, with wrap=0.

Reset
REQ-025 rst=1 SHALL set q to all-zeros if mode=0, to 1 (bit 0 set) if mode=1, with phase=0, wrap=0, illegal=0.
REQ-026 rst SHALL override load, en and pending correction in the same cycle; mid-count reset SHALL take effect at the next edge.

Structure
REQ-027 Shared package johnson_pkg SHALL hold mode constants (MODE_JOHNSON=0, MODE_RING=1), direction constants and the reset-code function.
REQ-028 A sub-module johnson_phase_decode SHALL compute legality and phase combinationally from q and mode; the top holds all registers.

Verification (WIDTH=4)
REQ-029 Reset, mode=0, dir=0, en=1 for 8 cycles -> q 0001,0011,0111,1111,1110,1100,1000,0000; phase 1..7,0; wrap=1 only on 0000.
REQ-030 From 0000, mode=0, dir=1, en=1 one cycle -> q=1000, phase=7, wrap=1.
REQ-031 Reset with mode=1, en=1, dir=0 for 4 cycles -> q 0010,0100,1000,0001; phase 1,2,3,0; wrap=1 on 0001.
REQ-032 mode=0, load=1, load_val=0101 -> q=0101, phase=0; next cycle q=0000, illegal=1, wrap=0; en=0 throughout gives same result.
REQ-033 mode=0 at q=0011, switch mode=1 -> next cycle q=0001, illegal=1; at q=0001 switch mode 1->0 -> no correction, counting continues 0011.
REQ-034 rst=1 with load=1, en=1 same cycle -> q=reset code, all pulses 0; then en=0, load=0 -> q holds for 3 cycles.
